// File: rtl/minmax_scan_ctrl.sv
// Sequential min/max scanner: takes N_SAMPLES 4-bit samples over a valid/ready
// handshake and tracks max/min with their earliest indices through one comparator.

module Comparator_4bit_str (
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic       A_greater,
    output logic       A_less,
    output logic       A_equal
);
    logic [3:0] bit_eq;
    logic [3:0] bit_gt;
    logic [3:0] bit_lt;
    logic [3:0] higher_eq;
    logic [3:0] gt_term;
    logic [3:0] lt_term;

    // A bit decides the result only when every more-significant bit pair matches.
    for (genvar gi = 0; gi < 4; gi++) begin : g_bit
        assign bit_eq[gi] = ~(A[gi] ^ B[gi]);
        assign bit_gt[gi] = A[gi] & ~B[gi];
        assign bit_lt[gi] = ~A[gi] & B[gi];
        if (gi == 3) begin : g_msb
            assign higher_eq[gi] = 1'b1;
        end else begin : g_low
            assign higher_eq[gi] = &bit_eq[3:gi+1];
        end
        assign gt_term[gi] = higher_eq[gi] & bit_gt[gi];
        assign lt_term[gi] = higher_eq[gi] & bit_lt[gi];
    end

    assign A_greater = |gt_term;
    assign A_less    = |lt_term;
    assign A_equal   = &bit_eq;
endmodule

module minmax_scan_ctrl #(
    parameter int N_SAMPLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       in_valid,
    input  logic [3:0] in_data,
    output logic       in_ready,
    output logic       busy,
    output logic       done,
    output logic [3:0] max_val,
    output logic [3:0] min_val,
    output logic [3:0] max_idx,
    output logic [3:0] min_idx
);
    localparam logic [3:0] LAST_IDX = 4'(N_SAMPLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CMP_MAX,
        S_CMP_MIN,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] hold_q, hold_d;
    logic [3:0] max_val_q, max_val_d;
    logic [3:0] min_val_q, min_val_d;
    logic [3:0] max_idx_q, max_idx_d;
    logic [3:0] min_idx_q, min_idx_d;

    logic [3:0] cmp_b;
    logic       cmp_gt;
    logic       cmp_lt;
    logic       cmp_eq_unused;

    // One comparator serves both phases; B follows whichever result is being tested.
    assign cmp_b = (state_q == S_CMP_MIN) ? min_val_q : max_val_q;

    Comparator_4bit_str u_cmp (
        .A         (hold_q),
        .B         (cmp_b),
        .A_greater (cmp_gt),
        .A_less    (cmp_lt),
        .A_equal   (cmp_eq_unused)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hold_q    <= '0;
            max_val_q <= '0;
            min_val_q <= '0;
            max_idx_q <= '0;
            min_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            max_val_q <= max_val_d;
            min_val_q <= min_val_d;
            max_idx_q <= max_idx_d;
            min_idx_q <= min_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        max_val_d = max_val_q;
        min_val_d = min_val_q;
        max_idx_d = max_idx_q;
        min_idx_d = min_idx_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (in_valid) begin
                    if (cnt_q == 4'd0) begin
                        max_val_d = in_data;
                        min_val_d = in_data;
                        max_idx_d = '0;
                        min_idx_d = '0;
                        cnt_d     = 4'd1;
                    end else begin
                        hold_d  = in_data;
                        state_d = S_CMP_MAX;
                    end
                end
            end
            // Strict compares only: a tie keeps the earlier index.
            S_CMP_MAX: begin
                if (cmp_gt) begin
                    max_val_d = hold_q;
                    max_idx_d = cnt_q;
                end
                state_d = S_CMP_MIN;
            end
            S_CMP_MIN: begin
                if (cmp_lt) begin
                    min_val_d = hold_q;
                    min_idx_d = cnt_q;
                end
                if (cnt_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                    state_d = S_LOAD;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready = (state_q == S_LOAD);
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign max_val  = max_val_q;
    assign min_val  = min_val_q;
    assign max_idx  = max_idx_q;
    assign min_idx  = min_idx_q;
endmodule

// File: tb/tb_minmax_scan_ctrl.sv
// Bench for minmax_scan_ctrl: directed scan table, hand-written reset sequences
// and random scans checked against an array-based min/max model.

module tb_minmax_scan_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = '0;

    logic       r8_ready, r8_busy, r8_done;
    logic [3:0] r8_maxv, r8_minv, r8_maxi, r8_mini;
    logic       r2_ready, r2_busy, r2_done;
    logic [3:0] r2_maxv, r2_minv, r2_maxi, r2_mini;

    int sel = 0;
    logic       m_ready, m_busy, m_done;
    logic [15:0] m_res;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    minmax_scan_ctrl #(.N_SAMPLES(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(r8_ready), .busy(r8_busy), .done(r8_done),
        .max_val(r8_maxv), .min_val(r8_minv), .max_idx(r8_maxi), .min_idx(r8_mini)
    );

    minmax_scan_ctrl #(.N_SAMPLES(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(r2_ready), .busy(r2_busy), .done(r2_done),
        .max_val(r2_maxv), .min_val(r2_minv), .max_idx(r2_maxi), .min_idx(r2_mini)
    );

    always_comb begin
        if (sel == 1) begin
            m_ready = r2_ready; m_busy = r2_busy; m_done = r2_done;
            m_res   = {r2_maxv, r2_maxi, r2_minv, r2_mini};
        end else begin
            m_ready = r8_ready; m_busy = r8_busy; m_done = r8_done;
            m_res   = {r8_maxv, r8_maxi, r8_minv, r8_mini};
        end
    end

    typedef struct packed {
        int          n;
        logic [31:0] s;       // sample i in s[4*i +: 4]
        int          mode;    // 0: in_valid held high, 1: toggles each cycle
        bit          poke;    // pulse start while busy
        logic [15:0] exp_res; // {max_val, max_idx, min_val, min_idx}
        int          exp_done; // -1: only require done later than back-to-back
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic [15:0] model(input logic [31:0] s, input int n);
        logic [3:0] mx, mn, mxi, mni, v;
        mx = s[3:0]; mn = s[3:0]; mxi = 4'd0; mni = 4'd0;
        for (int i = 1; i < n; i++) begin
            v = s[4*i +: 4];
            if (v > mx) begin mx = v; mxi = 4'(i); end
            if (v < mn) begin mn = v; mni = 4'(i); end
        end
        return {mx, mxi, mn, mni};
    endfunction

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic run_scan(input int n, input logic [31:0] s, input int mode, input bit poke,
                            output int done_cyc, output int done_cnt, output int bad_ready,
                            output logic [15:0] res_done, output logic [15:0] res_late);
        int k, gap, tail;
        k = 0; gap = 0; tail = 0;
        done_cyc = -1; done_cnt = 0; bad_ready = 0; res_done = '0; res_late = '0;
        @(posedge clk); #1;
        start = 1'b1; in_valid = 1'b1; in_data = s[3:0];
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (m_done) begin
                done_cnt++; done_cyc = cyc; res_done = m_res;
            end
            // the two cycles after a compared sample is taken must not be ready
            if (m_ready && gap > 0) bad_ready++;
            if (gap > 0) gap--;
            if (in_valid && m_ready) begin
                if (k >= 1) gap = 2;
                k++;
            end
            if (done_cnt > 0) tail++;
            if (tail >= 4) begin
                res_late = m_res;
                break;
            end
            @(posedge clk); #1;
            start    = poke && (done_cnt == 0) && (cyc % 4 == 1);
            in_valid = (mode == 0) ? 1'b1 : ((cyc + 1) % 2 == 0);
            in_data  = (k < n) ? s[4*k +: 4] : 4'($urandom);
        end
        start = 1'b0; in_valid = 1'b0;
    endtask

    task automatic scan_and_check(input string tag, input vec_t v);
        int dc, dn, br;
        logic [15:0] rd, rl;
        sel = (v.n == 2) ? 1 : 0;
        run_scan(v.n, v.s, v.mode, v.poke, dc, dn, br, rd, rl);
        $display("scan %s: n=%0d mode=%0d done_cycle=%0d done_pulses=%0d res=%h exp=%h",
                 tag, v.n, v.mode, dc, dn, rd, v.exp_res);
        chk({tag, " done_pulses"}, dn, 1);
        if (v.exp_done >= 0) chk({tag, " done_cycle"}, dc, v.exp_done);
        else chk({tag, " done_delayed"}, int'(dc > 3 * v.n - 1), 1);
        chk({tag, " ready_in_cmp"}, br, 0);
        chk({tag, " max_val"}, int'(rd[15:12]), int'(v.exp_res[15:12]));
        chk({tag, " max_idx"}, int'(rd[11:8]),  int'(v.exp_res[11:8]));
        chk({tag, " min_val"}, int'(rd[7:4]),   int'(v.exp_res[7:4]));
        chk({tag, " min_idx"}, int'(rd[3:0]),   int'(v.exp_res[3:0]));
        chk({tag, " stable_after_done"}, int'(rl), int'(v.exp_res));
        do_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        vec_t rv;
        int   cnt, dn;

        vecs[0] = '{n: 8, s: 32'h270F9193, mode: 0, poke: 1'b0, exp_res: 16'hF405, exp_done: 23};
        vecs[1] = '{n: 8, s: 32'h55555555, mode: 0, poke: 1'b0, exp_res: 16'h5050, exp_done: 23};
        vecs[2] = '{n: 8, s: 32'h27722772, mode: 0, poke: 1'b0, exp_res: 16'h7120, exp_done: 23};
        vecs[3] = '{n: 8, s: 32'h270F9193, mode: 1, poke: 1'b0, exp_res: 16'hF405, exp_done: -1};
        vecs[4] = '{n: 8, s: 32'h270F9193, mode: 0, poke: 1'b1, exp_res: 16'hF405, exp_done: 23};
        vecs[5] = '{n: 2, s: 32'h0000000F, mode: 0, poke: 1'b0, exp_res: 16'hF001, exp_done: 5};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs_n8", int'({r8_ready, r8_busy, r8_done, r8_maxv, r8_maxi, r8_minv, r8_mini}), 0);
        chk("reset_outputs_n2", int'({r2_ready, r2_busy, r2_done, r2_maxv, r2_maxi, r2_minv, r2_mini}), 0);

        for (int i = 0; i < 6; i++) scan_and_check($sformatf("vec%0d", i), vecs[i]);

        // reset one cycle after the fourth sample is taken aborts the scan
        sel = 0;
        @(posedge clk); #1 start = 1'b1; in_valid = 1'b1; in_data = 4'($urandom);
        cnt = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge clk);
            if (in_valid && m_ready) cnt++;
            if (cnt == 4) break;
            @(posedge clk); #1 start = 1'b0; in_data = 4'($urandom);
        end
        @(posedge clk); #1 rst = 1'b1; start = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        $display("abort: samples_taken=%0d outputs=%h busy=%0d", cnt, m_res, m_busy);
        chk("abort_samples_taken", cnt, 4);
        chk("abort_outputs_zero", int'({m_ready, m_busy, m_done, m_res}), 0);
        dn = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (m_done) dn++;
        end
        chk("abort_no_done", dn, 0);

        // reset wins over a simultaneous start
        @(posedge clk); #1 rst = 1'b1; start = 1'b1;
        @(posedge clk); #1 rst = 1'b0; start = 1'b0;
        @(negedge clk);
        $display("rst_vs_start: busy=%0d", m_busy);
        chk("rst_priority_busy", int'(m_busy), 0);
        in_valid = 1'b0;
        do_reset();

        for (int i = 0; i < 8; i++) begin
            rv.n = 8;
            rv.mode = int'($urandom_range(0, 1));
            rv.poke = 1'(i % 3 == 0);
            for (int j = 0; j < 8; j++)
                rv.s[4*j +: 4] = (i % 2 == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
            rv.exp_res = model(rv.s, rv.n);
            rv.exp_done = (rv.mode == 0) ? 23 : -1;
            scan_and_check($sformatf("rand%0d", i), rv);
        end
        for (int i = 0; i < 3; i++) begin
            rv.n = 2; rv.mode = 0; rv.poke = 1'b0;
            rv.s = $urandom;
            rv.exp_res = model(rv.s, rv.n);
            rv.exp_done = 5;
            scan_and_check($sformatf("rand_n2_%0d", i), rv);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
